// File: rtl/mdr_mar_unit.sv
// mdr_mar_unit: MAR/MDR capture from the datapath bus plus an SRAM
// read/write cycle sequencer with active-low chip controls.
// Optional build macro GATE_CHECK_EN: adds Gates[3:0] and a sticky Bus_Err
// that flags (and suppresses) register loads while the bus is not driven
// by exactly one source.
module mdr_mar_unit #(
    parameter int WIDTH       = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Bus,
    input  logic             LD_MAR,
    input  logic             LD_MDR,
    input  logic             Start,
    input  logic             RW,
`ifdef GATE_CHECK_EN
    input  logic [3:0]       Gates,
    output logic             Bus_Err,
`endif
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] MAR,
    output logic [WIDTH-1:0] MDR,
    output logic [WIDTH-1:0] ADDR,
    output logic [WIDTH-1:0] Data_to_SRAM,
    input  logic [WIDTH-1:0] Data_from_SRAM,
    output logic             CE_n,
    output logic             OE_n,
    output logic             WE_n
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    // Counter reload: ACCESS lasts WAIT_STATES cycles, counting down to zero.
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [WIDTH-1:0] mar_q, mar_d;
    logic [WIDTH-1:0] mdr_q, mdr_d;
    logic             ld_mar_ok, ld_mdr_ok;

`ifdef GATE_CHECK_EN
    logic gates_ok;
    logic bus_err_q;

    // A load is only trusted when exactly one gate drives the bus.
    always_comb begin
        gates_ok  = (Gates != 4'd0) && ((Gates & (Gates - 4'd1)) == 4'd0);
        ld_mar_ok = LD_MAR && gates_ok;
        ld_mdr_ok = LD_MDR && gates_ok;
    end

    // Sticky error flag: set by a suppressed load in IDLE, cleared only by reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus_err_q <= 1'b0;
        end else if (state_q == S_IDLE && (LD_MAR || LD_MDR) && !gates_ok) begin
            bus_err_q <= 1'b1;
        end
    end

    assign Bus_Err = bus_err_q;
`else
    assign ld_mar_ok = LD_MAR;
    assign ld_mdr_ok = LD_MDR;
`endif

    // Next-state, register loads, read capture and countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        case (state_q)
            S_IDLE: begin
                if (ld_mar_ok) mar_d = Bus;
                if (ld_mdr_ok) mdr_d = Bus;
                if (Start) begin
                    wr_d = RW;
                    if (RW) begin
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_ACCESS;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = CNT_INIT;
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!wr_q) mdr_d = Data_from_SRAM;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset aborts any operation in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            mar_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
        end
    end

    // SRAM controls decoded from state; writes keep CE_n low through the hold cycle.
    always_comb begin
        Busy = (state_q != S_IDLE);
        Done = (state_q == S_FINISH);
        CE_n = 1'b1;
        OE_n = 1'b1;
        WE_n = 1'b1;
        case (state_q)
            S_SETUP:  CE_n = 1'b0;
            S_ACCESS: begin
                CE_n = 1'b0;
                OE_n = wr_q;
                WE_n = !wr_q;
            end
            S_FINISH: CE_n = !wr_q;
            default:  CE_n = 1'b1;
        endcase
    end

    assign MAR          = mar_q;
    assign MDR          = mdr_q;
    assign ADDR         = mar_q;
    assign Data_to_SRAM = mdr_q;

endmodule

// File: tb/tb_mdr_mar_unit.sv
// Directed bench for mdr_mar_unit (WIDTH=16, WAIT_STATES=2).
// Cycle 0 is the cycle in which Start is driven; inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_mdr_mar_unit;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [15:0] Bus = '0;
    logic        LD_MAR = 1'b0, LD_MDR = 1'b0, Start = 1'b0, RW = 1'b0;
    logic        Busy, Done, CE_n, OE_n, WE_n;
    logic [15:0] MAR, MDR, ADDR, Data_to_SRAM;
    logic [15:0] Data_from_SRAM = '0;
`ifdef GATE_CHECK_EN
    logic [3:0]  Gates = 4'b0001;
    logic        Bus_Err;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 Clk = ~Clk;

    mdr_mar_unit #(.WIDTH(16), .WAIT_STATES(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Bus(Bus),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .Start(Start), .RW(RW),
`ifdef GATE_CHECK_EN
        .Gates(Gates), .Bus_Err(Bus_Err),
`endif
        .Busy(Busy), .Done(Done), .MAR(MAR), .MDR(MDR), .ADDR(ADDR),
        .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
        .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        LD_MAR = 1'b0; LD_MDR = 1'b0; Start = 1'b0; RW = 1'b0;
    endtask

    // Steps until Done is seen; returns cycles stepped, or -1 past the bound.
    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (Done) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        int c, ndone, gap;

        // Reset state
        Reset_n = 1'b1;
        #1 Reset_n = 1'b0;
        #2;
        chk("rst_MAR", MAR, 16'h0000);
        chk("rst_MDR", MDR, 16'h0000);
        chk("rst_Busy", {15'd0, Busy}, 16'd0);
        chk("rst_Done", {15'd0, Done}, 16'd0);
        chk("rst_ctl", {13'd0, CE_n, OE_n, WE_n}, 16'h0007);
        @(posedge Clk);
        @(negedge Clk) Reset_n = 1'b1;
        step();

        // Reset asserted mid-ACCESS of a read aborts without capturing
        Data_from_SRAM = 16'hBEEF;
        Start = 1'b1; RW = 1'b0;
        step(); clr();
        chk("abort_in_access_OE", {15'd0, OE_n}, 16'd0);
        #2 Reset_n = 1'b0;
        #1;
        chk("abort_ctl_async", {13'd0, CE_n, OE_n, WE_n}, 16'h0007);
        chk("abort_Busy", {15'd0, Busy}, 16'd0);
        @(posedge Clk);
        @(negedge Clk) Reset_n = 1'b1;
        step();
        chk("abort_MDR", MDR, 16'h0000);
        chk("abort_Busy_after", {15'd0, Busy}, 16'd0);

        // Read: LD_MAR + Start in the same cycle
        Bus = 16'h3000; LD_MAR = 1'b1; Start = 1'b1; RW = 1'b0;
        Data_from_SRAM = 16'h1234;
        step(); clr(); Bus = 16'h0000;
        chk("rd_c1_ctl", {13'd0, CE_n, OE_n, WE_n}, 16'h0001);
        chk("rd_c1_Busy", {15'd0, Busy}, 16'd1);
        chk("rd_c1_Done", {15'd0, Done}, 16'd0);
        chk("rd_ADDR", ADDR, 16'h3000);
        step();
        chk("rd_c2_ctl", {13'd0, CE_n, OE_n, WE_n}, 16'h0001);
        chk("rd_c2_Done", {15'd0, Done}, 16'd0);
        step();
        chk("rd_c3_Done", {15'd0, Done}, 16'd1);
        chk("rd_c3_MDR", MDR, 16'h1234);
        chk("rd_c3_ctl", {13'd0, CE_n, OE_n, WE_n}, 16'h0007);
        step();
        chk("rd_c4_Done", {15'd0, Done}, 16'd0);
        chk("rd_c4_Busy", {15'd0, Busy}, 16'd0);

        // Write: LD_MAR, then LD_MDR + Start(RW=1)
        Bus = 16'h0042; LD_MAR = 1'b1;
        step(); clr();
        Bus = 16'hA5A5; LD_MDR = 1'b1; Start = 1'b1; RW = 1'b1;
        step(); clr(); Bus = 16'h0000;
        chk("wr_c1_setup_ctl", {13'd0, CE_n, OE_n, WE_n}, 16'h0003);
        chk("wr_c1_ADDR", ADDR, 16'h0042);
        chk("wr_c1_data", Data_to_SRAM, 16'hA5A5);
        step();
        chk("wr_c2_ctl", {13'd0, CE_n, OE_n, WE_n}, 16'h0002);
        step();
        chk("wr_c3_ctl", {13'd0, CE_n, OE_n, WE_n}, 16'h0002);
        chk("wr_c3_data", Data_to_SRAM, 16'hA5A5);
        chk("wr_c3_Done", {15'd0, Done}, 16'd0);
        step();
        chk("wr_c4_Done", {15'd0, Done}, 16'd1);
        chk("wr_c4_hold_ctl", {13'd0, CE_n, OE_n, WE_n}, 16'h0003);
        chk("wr_c4_ADDR", ADDR, 16'h0042);
        chk("wr_MDR_kept", MDR, 16'hA5A5);
        step();
        chk("wr_c5_Busy", {15'd0, Busy}, 16'd0);

        // Busy guard: load and second Start during a read are ignored
        Data_from_SRAM = 16'h7777;
        Start = 1'b1; RW = 1'b0;
        step(); clr();
        Bus = 16'hFFFF; LD_MAR = 1'b1; Start = 1'b1; RW = 1'b1;
        ndone = 0;
        step(); clr(); Bus = 16'h0000;
        chk("guard_MAR", MAR, 16'h0042);
        for (int i = 0; i < 8; i++) begin
            if (Done) ndone++;
            step();
        end
        chk("guard_done_count", 16'(ndone), 16'd1);
        chk("guard_MDR", MDR, 16'h7777);
        chk("guard_idle", {15'd0, Busy}, 16'd0);

        // Back-to-back reads: second Start in the IDLE cycle right after Done
        Data_from_SRAM = 16'h1111;
        Start = 1'b1; RW = 1'b0;
        step(); clr();
        wait_done(c);
        chk("b2b_first_latency", 16'(c), 16'd2);
        chk("b2b_first_MDR", MDR, 16'h1111);
        step();
        chk("b2b_gap_idle", {15'd0, Busy}, 16'd0);
        chk("b2b_no_double_done", {15'd0, Done}, 16'd0);
        Data_from_SRAM = 16'h2222;
        Start = 1'b1; RW = 1'b0;
        step(); clr();
        chk("b2b_second_accept", {15'd0, Busy}, 16'd1);
        wait_done(gap);
        chk("b2b_second_latency", 16'(gap), 16'd2);
        chk("b2b_second_MDR", MDR, 16'h2222);
        step();

`ifdef GATE_CHECK_EN
        // Gate check: non-one-hot gates suppress the load and set sticky error
        chk("gate_err_init", {15'd0, Bus_Err}, 16'd0);
        Gates = 4'b1100; Bus = 16'h5555; LD_MDR = 1'b1;
        step(); clr();
        chk("gate_bad_MDR", MDR, 16'h2222);
        chk("gate_err_set", {15'd0, Bus_Err}, 16'd1);
        Gates = 4'b0001; LD_MDR = 1'b1;
        step(); clr();
        chk("gate_ok_MDR", MDR, 16'h5555);
        chk("gate_err_sticky", {15'd0, Bus_Err}, 16'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
